// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector of a small combinational function
// (1..4 inputs), lets each vector settle for a programmable dwell, samples the
// function output and compares it against a golden truth table.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       sweep request, accepted only when idle
//   num_inputs  number of function inputs (0 is treated as 1, >4 as 4)
//   dwell       settle cycles per vector (0 is treated as 1)
//   expected    golden truth table, bit k is the expected output for vector k
//   dut_out     output of the function under test
//   vec         vector driven to the function under test
//   busy        high while driving/sampling
//   done        one-cycle pulse at the end of a sweep
//   pass        last completed sweep had no mismatches
//   err_count   mismatch count of the current/last sweep
//   first_fail  index of the first mismatching vector
//   fail_valid  first_fail holds a captured index
module truth_table_sweeper #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         num_inputs,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        expected,
  input  logic               dut_out,
  output logic [3:0]         vec,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [4:0]         err_count,
  output logic [3:0]         first_fail,
  output logic               fail_valid
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e             state_q;
  logic [2:0]         n_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [15:0]        expected_q;

  logic [2:0]         n_clamped;
  logic [DWELL_W-1:0] dwell_eff;
  logic [3:0]         last_vec;
  logic               mismatch;
  logic [4:0]         err_next;

  always_comb begin
    n_clamped = num_inputs;
    if (num_inputs == 3'd0) begin
      n_clamped = 3'd1;
    end else if (num_inputs > 3'd4) begin
      n_clamped = 3'd4;
    end
  end

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    case (n_q)
      3'd1:    last_vec = 4'h1;
      3'd2:    last_vec = 4'h3;
      3'd3:    last_vec = 4'h7;
      default: last_vec = 4'hF;
    endcase
  end

  assign mismatch = (dut_out != expected_q[vec]);

  // Count after this SAMPLE; used so pass is valid in the same cycle as done.
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != 5'd16)) begin
      err_next = err_count + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= 3'd1;
      dwell_q     <= DWELL_W'(1);
      dwell_cnt_q <= '0;
      expected_q  <= '0;
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_fail  <= '0;
      fail_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q         <= n_clamped;
            dwell_q     <= dwell_eff;
            expected_q  <= expected;
            dwell_cnt_q <= '0;
            vec         <= '0;
            err_count   <= '0;
            first_fail  <= '0;
            fail_valid  <= 1'b0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StDrive;
          end
        end
        StDrive: begin
          if (dwell_cnt_q == dwell_q - DWELL_W'(1)) begin
            state_q <= StSample;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
          end
        end
        StSample: begin
          err_count   <= err_next;
          dwell_cnt_q <= '0;
          if (mismatch && !fail_valid) begin
            first_fail <= vec;
            fail_valid <= 1'b1;
          end
          if (vec == last_vec) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next == 5'd0);
            state_q <= StDone;
          end else begin
            vec     <= vec + 4'd1;
            state_q <= StDrive;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a cycle-count based reference model predicts every
// output each cycle from the accepted configuration; directed sweeps pin the model
// with hand-computed results, then randomized sweeps with mid-sweep disturbances
// and resets are checked against it.
module tb_truth_table_sweeper;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    num_inputs;
  logic [DW-1:0] dwell;
  logic [15:0]   expected;
  logic [15:0]   dut_tab;
  logic          dut_out;
  logic [3:0]    vec;
  logic          busy;
  logic          done;
  logic          pass;
  logic [4:0]    err_count;
  logic [3:0]    first_fail;
  logic          fail_valid;

  int total = 0;
  int bad   = 0;

  // Function under test is a lookup table chosen by the bench.
  assign dut_out = dut_tab[vec];

  truth_table_sweeper #(.DWELL_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_inputs (num_inputs),
    .dwell      (dwell),
    .expected   (expected),
    .dut_out    (dut_out),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sweep position is a cycle count c since acceptance; vector k occupies
  // c in [k*(D+1), (k+1)*(D+1)) and its result is known from c >= (k+1)*(D+1).
  bit          m_ok = 0, m_active = 0, m_was_done = 0;
  int          m_c, m_n, m_d, m_len;
  logic [15:0] m_exp, m_tab;
  int          m_vec = 0, m_err = 0, m_ff = 0;
  bit          m_busy = 0, m_done = 0, m_pass = 0, m_fv = 0;

  always @(posedge clk) begin
    m_was_done = m_done;
    m_done = 0;
    if (rst) begin
      m_ok = 1; m_active = 0; m_vec = 0; m_busy = 0; m_pass = 0;
      m_err = 0; m_ff = 0; m_fv = 0;
    end else if (m_ok) begin
      if (m_active) begin
        m_c++;
        m_len = (1 << m_n) * (m_d + 1);
        if (m_c < m_len) begin
          m_vec = m_c / (m_d + 1);
        end else begin
          m_busy = 0; m_done = 1; m_active = 0;
        end
        m_err = 0; m_fv = 0; m_ff = 0;
        for (int j = 0; j < (1 << m_n); j++) begin
          if ((j + 1) * (m_d + 1) <= m_c && m_tab[j] != m_exp[j]) begin
            m_err++;
            if (!m_fv) begin m_fv = 1; m_ff = j; end
          end
        end
        if (m_done) m_pass = (m_err == 0);
      end else if (start && !m_was_done) begin
        m_n = (num_inputs == 0) ? 1 : ((num_inputs > 4) ? 4 : int'(num_inputs));
        m_d = (dwell == 0) ? 1 : int'(dwell);
        m_exp = expected; m_tab = dut_tab;
        m_c = 0; m_active = 1; m_busy = 1; m_vec = 0;
        m_err = 0; m_ff = 0; m_fv = 0; m_pass = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      cmp("model vec", vec, m_vec);
      cmp("model busy", busy, m_busy);
      cmp("model done", done, m_done);
      cmp("model pass", pass, m_pass);
      cmp("model err_count", err_count, m_err);
      cmp("model first_fail", first_fail, m_ff);
      cmp("model fail_valid", fail_valid, m_fv);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setup(input logic [2:0] n, input int d, input logic [15:0] e,
                       input logic [15:0] tab);
    @(negedge clk);
    num_inputs = n; dwell = DW'(d); expected = e; dut_tab = tab; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge 0 until done is seen (bounded).
  task automatic wait_done(input int e0, input int limit, output int e);
    e = e0;
    while (done !== 1'b1 && e < limit) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] n, input int d,
                     input logic [15:0] e, input logic [15:0] tab, input int exp_edge);
    int edge_n;
    setup(n, d, e, tab);
    wait_done(0, 300, edge_n);
    cmp({name, " done edge"}, edge_n, exp_edge);
  endtask

  initial begin
    int e;
    int seen_done;
    rst = 1'b1; start = 1'b0; num_inputs = 3'd0; dwell = '0;
    expected = '0; dut_tab = '0;
    repeat (3) @(negedge clk);
    cmp("reset vec", vec, 0);
    cmp("reset busy", busy, 0);
    cmp("reset done", done, 0);
    cmp("reset pass", pass, 0);
    cmp("reset err_count", err_count, 0);
    cmp("reset first_fail", first_fail, 0);
    cmp("reset fail_valid", fail_valid, 0);
    rst = 1'b0;

    // OR function checked against an OR table.
    run("or_pass", 3'd2, 3, 16'h000E, 16'hEEEE, 16);
    cmp("or_pass pass", pass, 1);
    cmp("or_pass err", err_count, 0);
    cmp("or_pass fv", fail_valid, 0);

    // OR function checked against an AND table: vectors 1 and 2 mismatch.
    run("or_vs_and", 3'd2, 1, 16'h0008, 16'hEEEE, 8);
    cmp("or_vs_and err", err_count, 2);
    cmp("or_vs_and ff", first_fail, 1);
    cmp("or_vs_and fv", fail_valid, 1);
    cmp("or_vs_and pass", pass, 0);

    // 4-input parity with dwell 0 (treated as 1).
    run("xor4", 3'd4, 0, 16'h6996, 16'h6996, 32);
    cmp("xor4 pass", pass, 1);
    cmp("xor4 last vec", vec, 15);

    // Clamping of num_inputs.
    run("n0", 3'd0, 1, 16'h0002, 16'hAAAA, 4);
    cmp("n0 last vec", vec, 1);
    cmp("n0 pass", pass, 1);
    run("n7", 3'd7, 0, 16'h1234, 16'h1234, 32);
    cmp("n7 last vec", vec, 15);

    // Every vector mismatches: count reaches 16 exactly.
    run("all_bad", 3'd4, 1, 16'h0000, 16'hFFFF, 32);
    cmp("all_bad err", err_count, 16);
    cmp("all_bad ff", first_fail, 0);

    // Start and config changes mid-sweep are ignored.
    setup(3'd2, 2, 16'h000E, 16'hEEEE);
    wait_done(0, 3, e);
    start = 1'b1; num_inputs = 3'd4; expected = 16'h0000; dwell = DW'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done(e + 1, 300, e);
    cmp("midsweep done edge", e, 12);
    cmp("midsweep pass", pass, 1);
    cmp("midsweep err", err_count, 0);

    // Reset while driving vector 5.
    setup(3'd4, 2, 16'hFFFF, 16'h0F0F);
    repeat (15) @(negedge clk);
    cmp("pre-reset vec", vec, 5);
    cmp("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort vec", vec, 0);
    cmp("abort busy", busy, 0);
    cmp("abort err", err_count, 0);
    cmp("abort fv", fail_valid, 0);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    cmp("abort no done", seen_done, 0);
    run("after_abort", 3'd4, 2, 16'h0F0F, 16'h0F0F, 48);
    cmp("after_abort pass", pass, 1);

    // Randomized sweeps with mid-sweep disturbances and occasional resets.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] tab;
      logic [15:0] flips;
      bit          aborted;
      tab   = 16'($urandom);
      flips = 16'($urandom) & 16'($urandom) & 16'($urandom);
      setup(3'($urandom_range(0, 7)), $urandom_range(0, 3), tab ^ flips, tab);
      e = 0;
      aborted = 0;
      while (done !== 1'b1 && e < 300 && !aborted) begin
        @(negedge clk);
        e++;
        start = 1'b0;
        rst   = 1'b0;
        if (done !== 1'b1) begin
          if ($urandom_range(0, 7) == 0) begin
            start = 1'b1;
            num_inputs = 3'($urandom);
            dwell = DW'($urandom_range(0, 5));
            expected = 16'($urandom);
          end
          if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            aborted = 1;
          end
        end
      end
      if (!aborted) begin
        cmp("rand done seen", done, 1);
        // Start held during DONE must be ignored.
        if ($urandom_range(0, 1) == 1) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
